// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter sharing one single-port memory between an instruction
//   fetch port (read only) and a data port (read/write). Each transaction runs
//   IDLE -> ACCESS -> RESP. The granted port sees its waitrequest low for the
//   RESP cycle only. A waiting port is served straight from RESP, so requests
//   that are held on both ports alternate I, D, I, D.
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     i_address/i_read    instruction fetch request
//     i_readdata          fetched word, held between completions
//     i_waitrequest       low only in the instruction completion cycle
//     d_address/d_read/d_write/d_writedata
//                         data request; read+write together is a plain write
//     d_readdata          read word, held between completions
//     d_waitrequest       low only in the data completion cycle
//     mem_*               shared memory; read data is combinational from
//                         mem_address, and a write lands on the clk edge that
//                         ends the ACCESS cycle
//
//   state  | meaning
//   IDLE   | no transaction; pick a winner when any request is pending
//   ACCESS | memory strobes driven for the granted port; read data captured
//   RESP   | granted port completes; hand over to the other port if it waits
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] i_readdata,
  output logic                  i_waitrequest,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_writedata,
  output logic [DATA_WIDTH-1:0] d_readdata,
  output logic                  d_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;    // 0 = instruction, 1 = data
  logic                  last_q, last_d;  // port served most recently
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  i_req, d_req;
  logic                  acc_read, acc_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign sel_addr  = gnt_q ? d_address : i_address;
  // The fetch port has no write data, so the bus keeps its last value.
  assign sel_wdata = gnt_q ? d_writedata : wdata_q;
  // Read and write together on the data port is a write with no read strobe.
  assign acc_write = gnt_q & d_write;
  assign acc_read  = ~gnt_q | (d_read & ~d_write);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_ACCESS;
          // On a tie the port that was not served last wins.
          gnt_d   = (i_req && d_req) ? ~last_q : d_req;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        last_d  = gnt_q;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        if (acc_read) begin
          if (gnt_q) d_rdata_d = mem_readdata;
          else       i_rdata_d = mem_readdata;
        end
      end
      ST_RESP: begin
        if (gnt_q ? i_req : d_req) begin
          state_d = ST_ACCESS;
          gnt_d   = ~gnt_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Strobes are gated by reset so an ACCESS cut short by reset never writes.
  assign mem_write     = ~reset & (state_q == ST_ACCESS) & acc_write;
  assign mem_read      = ~reset & (state_q == ST_ACCESS) & acc_read;
  assign mem_address   = (state_q == ST_ACCESS) ? sel_addr  : addr_q;
  assign mem_writedata = (state_q == ST_ACCESS) ? sel_wdata : wdata_q;

  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign i_waitrequest = reset | ~((state_q == ST_RESP) & ~gnt_q);
  assign d_waitrequest = reset | ~((state_q == ST_RESP) &  gnt_q);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, d_address, d_writedata;
  logic        i_read, d_read, d_write;
  logic [31:0] i_readdata, d_readdata;
  logic        i_waitrequest, d_waitrequest;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_write, mem_read;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read),
    .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_readdata(d_readdata),
    .d_waitrequest(d_waitrequest),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_readdata(mem_readdata)
  );

  // Memory model: combinational read, word addressed, write on clock edge.
  assign mem_readdata = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (pre_we)         mem[pre_idx] <= pre_data;
    else if (mem_write) mem[mem_address[7:2]] <= mem_writedata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    tick();
    pre_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    i_address = '0; d_address = '0; d_writedata = '0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    tick();
    for (int w = 0; w < 64; w++) preload(6'(w), 32'h0);
    preload(6'd4,  32'hDEADBEEF);
    preload(6'd16, 32'hCAFEF00D);

    // Reset values
    check("rst_i_wait", {31'd0, i_waitrequest}, 32'd1);
    check("rst_d_wait", {31'd0, d_waitrequest}, 32'd1);
    check("rst_mem_rd", {31'd0, mem_read}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_write}, 32'd0);
    check("rst_i_rdata", i_readdata, 32'h0);
    check("rst_d_rdata", d_readdata, 32'h0);
    reset = 1'b0;
    tick();

    // Single fetch from 0x10
    i_read = 1'b1; i_address = 32'h10;
    #1 check("f_idle_wait", {31'd0, i_waitrequest}, 32'd1);
    tick();
    check("f_acc_rd", {31'd0, mem_read}, 32'd1);
    check("f_acc_addr", mem_address, 32'h10);
    check("f_acc_wait", {31'd0, i_waitrequest}, 32'd1);
    tick();
    check("f_resp_wait", {31'd0, i_waitrequest}, 32'd0);
    check("f_resp_data", i_readdata, 32'hDEADBEEF);
    check("f_resp_dwait", {31'd0, d_waitrequest}, 32'd1);
    check("f_resp_rd", {31'd0, mem_read}, 32'd0);
    i_read = 1'b0;
    tick();
    check("f_after_wait", {31'd0, i_waitrequest}, 32'd1);
    check("f_after_hold", i_readdata, 32'hDEADBEEF);

    // Data write then read back at 0x20
    d_write = 1'b1; d_address = 32'h20; d_writedata = 32'h12345678;
    tick();
    check("w_acc_wr", {31'd0, mem_write}, 32'd1);
    check("w_acc_rd", {31'd0, mem_read}, 32'd0);
    tick();
    check("w_resp_wait", {31'd0, d_waitrequest}, 32'd0);
    check("w_mem8", mem[8], 32'h12345678);
    d_write = 1'b0;
    tick();
    check("w_addr_hold", mem_address, 32'h20);
    d_read = 1'b1;
    tick();
    check("r_acc_rd", {31'd0, mem_read}, 32'd1);
    tick();
    check("r_resp_wait", {31'd0, d_waitrequest}, 32'd0);
    check("r_resp_data", d_readdata, 32'h12345678);
    check("r_i_hold", i_readdata, 32'hDEADBEEF);
    d_read = 1'b0;
    tick();

    // Simultaneous held requests from reset: I at +2, D at +4, then I, D again
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_read = 1'b1; i_address = 32'h10;
    d_read = 1'b1; d_address = 32'h20;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rr_i_wait_%0d", k), {31'd0, i_waitrequest},
            (k == 2 || k == 6) ? 32'd0 : 32'd1);
      check($sformatf("rr_d_wait_%0d", k), {31'd0, d_waitrequest},
            (k == 4 || k == 8) ? 32'd0 : 32'd1);
      if (k == 2) check("rr_i_data", i_readdata, 32'hDEADBEEF);
      if (k == 4) check("rr_d_data", d_readdata, 32'h12345678);
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
    check("rr_idle_i", {31'd0, i_waitrequest}, 32'd1);

    // Read and write together: write only, no read strobe
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0; d_writedata = 32'hA5A5A5A5;
    tick();
    check("rw_acc_rd", {31'd0, mem_read}, 32'd0);
    check("rw_acc_wr", {31'd0, mem_write}, 32'd1);
    tick();
    check("rw_resp_rd", {31'd0, mem_read}, 32'd0);
    check("rw_resp_wait", {31'd0, d_waitrequest}, 32'd0);
    check("rw_mem0", mem[0], 32'hA5A5A5A5);
    d_read = 1'b0; d_write = 1'b0;
    tick();

    // Reset during ACCESS of a write to 0x40
    d_write = 1'b1; d_address = 32'h40; d_writedata = 32'h11111111;
    tick();
    check("rs_acc_wr", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("rs_gate_wr", {31'd0, mem_write}, 32'd0);
    check("rs_gate_wait", {31'd0, d_waitrequest}, 32'd1);
    tick();
    check("rs_mem16", mem[16], 32'hCAFEF00D);
    check("rs_d_wait", {31'd0, d_waitrequest}, 32'd1);
    reset = 1'b0;
    tick();
    // Re-presented request starts from IDLE, so this cycle is ACCESS.
    check("rs_re_acc_wr", {31'd0, mem_write}, 32'd1);
    check("rs_re_acc_wait", {31'd0, d_waitrequest}, 32'd1);
    tick();
    check("rs_re_resp_wait", {31'd0, d_waitrequest}, 32'd0);
    check("rs_re_mem16", mem[16], 32'h11111111);
    d_write = 1'b0;
    tick();

    // Ten quiet cycles
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("q_rd_%0d", k), {31'd0, mem_read}, 32'd0);
      check($sformatf("q_wr_%0d", k), {31'd0, mem_write}, 32'd0);
      check($sformatf("q_iw_%0d", k), {31'd0, i_waitrequest}, 32'd1);
      check($sformatf("q_dw_%0d", k), {31'd0, d_waitrequest}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
